// File: rtl/tone_pkg.sv
// Shared constants and types for the tone decoder: the generator's note
// divider table, per-note acceptance thresholds and the decode FSM states.
package tone_pkg;

  localparam int unsigned NUM_NOTES = 12;

  // Normalised half-period range covered by one octave (m = P >> (8 - octave)).
  localparam logic [9:0] M_MIN = 10'd264;
  localparam logic [9:0] M_MAX = 10'd527;

  // Nominal divider per note (0=A ... 11=G#), as used by the generator.
  localparam logic [9:0] NOTE_NOM [NUM_NOTES] = '{
    10'd512, 10'd483, 10'd456, 10'd431, 10'd406, 10'd384,
    10'd362, 10'd342, 10'd323, 10'd304, 10'd287, 10'd271
  };

  // Lower acceptance bound per note; the first entry with m >= LO wins.
  localparam logic [9:0] NOTE_LO [NUM_NOTES] = '{
    10'd498, 10'd470, 10'd444, 10'd419, 10'd395, 10'd373,
    10'd352, 10'd333, 10'd314, 10'd296, 10'd279, 10'd264
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM   = 2'd1,
    MATCH  = 2'd2,
    REPORT = 2'd3
  } dec_state_e;

  // Linear note index across octaves: octave*12 + note (max 95).
  function automatic logic [6:0] full_note(input logic [2:0] oct, input logic [3:0] nt);
    return ({4'd0, oct} * 7'd12) + {3'd0, nt};
  endfunction

endpackage

// File: rtl/audio_edge_sync.sv
// Brings the asynchronous speaker line into the clock domain and emits a
// registered one-cycle pulse for every rising or falling transition.
module audio_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic audio_in,
  output logic edge_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-flop synchroniser, delayed copy and registered both-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      prev_r     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1_r    <= audio_in;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      edge_pulse <= sync2_r ^ prev_r;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Receive-side pitch decoder. Measures the half-period of the square-wave
// input, normalises it to one octave by shifting, looks the result up in the
// note threshold table and reports a note once it has been decoded
// identically STABLE_COUNT times in a row.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W        = 19,
  parameter int unsigned TIMEOUT      = 262144,
  parameter int unsigned STABLE_COUNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       audio_in,
  output logic       note_valid,
  output logic       silent,
  output logic [2:0] octave,
  output logic [3:0] note,
  output logic [6:0] fullnote,
  output logic       note_strobe,
  output logic       err_strobe
);

  localparam int unsigned STB_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [STB_W-1:0] STABLE_C  = STB_W'(STABLE_COUNT);

  // Edge detection and half-period counter
  logic             edge_s;
  logic [CNT_W-1:0] cnt_r;
  logic             first_edge_r;
  logic             capture_s;
  logic             silence_s;

  // Decode datapath
  dec_state_e       state_r;
  logic [CNT_W-1:0] p_r;
  logic [2:0]       oct_r;
  logic [9:0]       m_r;
  logic [3:0]       idx_r;
  logic [STB_W-1:0] stable_r;
  logic [2:0]       cand_oct_r;
  logic [3:0]       cand_note_r;

  logic [3:0]       shamt_s;
  logic [CNT_W-1:0] shifted_s;
  logic             in_range_s;
  logic             cand_match_s;
  logic [STB_W-1:0] stable_nxt_s;
  logic             report_s;

  audio_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .audio_in   (audio_in),
    .edge_pulse (edge_s)
  );

  // The first edge after reset or silence only starts timing; it has no
  // preceding edge to measure against.
  assign capture_s = edge_s & ~first_edge_r;
  assign silence_s = ~edge_s & (cnt_r == TIMEOUT_C);

  // Half-period counter, first-edge tracking and silence detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      first_edge_r <= 1'b1;
      silent       <= 1'b1;
    end else if (edge_s) begin
      cnt_r        <= CNT_W'(1'b1);
      first_edge_r <= 1'b0;
      silent       <= 1'b0;
    end else if (cnt_r == TIMEOUT_C) begin
      silent       <= 1'b1;
      first_edge_r <= 1'b1;
    end else begin
      cnt_r        <= cnt_r + CNT_W'(1'b1);
    end
  end

  // Octave normalisation: compare on the full counter width so large
  // periods are rejected rather than wrapping into range.
  always_comb begin
    shamt_s    = 4'd8 - {1'b0, oct_r};
    shifted_s  = p_r >> shamt_s;
    in_range_s = (shifted_s >= CNT_W'(M_MIN)) && (shifted_s <= CNT_W'(M_MAX));
  end

  // Stability counter update for the decode finishing in REPORT.
  always_comb begin
    cand_match_s = (cand_oct_r == oct_r) && (cand_note_r == idx_r);
    stable_nxt_s = STB_W'(1'b1);
    if (cand_match_s) begin
      if (stable_r >= STABLE_C) begin
        stable_nxt_s = STABLE_C;
      end else begin
        stable_nxt_s = stable_r + STB_W'(1'b1);
      end
    end else begin
      stable_nxt_s = STB_W'(1'b1);
    end
    report_s = (stable_nxt_s == STABLE_C) &&
               (({oct_r, idx_r} != {octave, note}) || !note_valid);
  end

  // Decode FSM with registered note outputs and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      p_r         <= '0;
      oct_r       <= 3'd0;
      m_r         <= 10'd0;
      idx_r       <= 4'd0;
      stable_r    <= '0;
      cand_oct_r  <= 3'd0;
      cand_note_r <= 4'd0;
      note_valid  <= 1'b0;
      octave      <= 3'd0;
      note        <= 4'd0;
      fullnote    <= 7'd0;
      note_strobe <= 1'b0;
      err_strobe  <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      err_strobe  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            p_r     <= cnt_r;
            oct_r   <= 3'd0;
            state_r <= NORM;
          end else begin
            state_r <= IDLE;
          end
        end
        NORM: begin
          if (in_range_s) begin
            m_r     <= shifted_s[9:0];
            idx_r   <= 4'd0;
            state_r <= MATCH;
          end else if (oct_r == 3'd7) begin
            err_strobe <= 1'b1;
            stable_r   <= '0;
            state_r    <= IDLE;
          end else begin
            oct_r <= oct_r + 3'd1;
          end
        end
        MATCH: begin
          // m >= M_MIN guarantees a hit by the last entry.
          if ((m_r >= NOTE_LO[idx_r]) || (idx_r >= 4'd11)) begin
            state_r <= REPORT;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        REPORT: begin
          stable_r    <= stable_nxt_s;
          cand_oct_r  <= oct_r;
          cand_note_r <= idx_r;
          if (report_s && !capture_s) begin
            octave      <= oct_r;
            note        <= idx_r;
            fullnote    <= full_note(oct_r, idx_r);
            note_valid  <= 1'b1;
            note_strobe <= 1'b1;
          end else begin
            note_valid  <= note_valid;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // A period that arrives while the previous one is still being decoded
      // cannot be processed; flag it and restart the stability run.
      if (capture_s && (state_r != IDLE)) begin
        err_strobe <= 1'b1;
        stable_r   <= '0;
      end

      if (silence_s) begin
        note_valid <= 1'b0;
        stable_r   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder. TIMEOUT is shortened so the whole run,
// including a silence timeout, stays short; octaves 3..7 remain reachable.
module tb_tone_decoder;

  localparam int TO  = 11000;
  localparam int CHK = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       audio_in;
  logic       note_valid;
  logic       silent;
  logic [2:0] octave;
  logic [3:0] note;
  logic [6:0] fullnote;
  logic       note_strobe;
  logic       err_strobe;

  int checks = 0;
  int errors = 0;
  int ns_cnt = 0;
  int er_cnt = 0;
  int ns0;
  int er0;

  typedef enum {A_EDGE, A_RESET, A_SILENCE} act_e;
  typedef struct {
    act_e act;
    int   half;
    int   s;
    int   v;
    int   o;
    int   n;
    int   ns;
    int   er;
  } vec_t;

  vec_t vecs[$];

  tone_decoder #(.CNT_W(19), .TIMEOUT(TO), .STABLE_COUNT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .audio_in    (audio_in),
    .note_valid  (note_valid),
    .silent      (silent),
    .octave      (octave),
    .note        (note),
    .fullnote    (fullnote),
    .note_strobe (note_strobe),
    .err_strobe  (err_strobe)
  );

  always #5 clk = ~clk;

  // Count strobe pulses seen at each rising edge.
  always @(posedge clk) begin
    if (note_strobe === 1'b1) ns_cnt <= ns_cnt + 1;
    if (err_strobe === 1'b1)  er_cnt <= er_cnt + 1;
  end

  function automatic vec_t mk(act_e a, int h, int s, int v, int o, int n, int ns, int er);
    vec_t t;
    t.act = a; t.half = h; t.s = s; t.v = v; t.o = o; t.n = n; t.ns = ns; t.er = er;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Toggle the pin exactly 'half' cycles after the previous toggle, then
  // move to the sampling point CHK cycles later.
  task automatic toggle_after(input int half);
    repeat (half - CHK) @(posedge clk);
    #1;
    ns0 = ns_cnt;
    er0 = er_cnt;
    audio_in = ~audio_in;
  endtask

  task automatic check_vec(input int k, input vec_t t);
    chk($sformatf("v%0d.silent", k), {31'd0, silent}, t.s);
    chk($sformatf("v%0d.valid", k), {31'd0, note_valid}, t.v);
    chk($sformatf("v%0d.octave", k), {29'd0, octave}, t.o);
    chk($sformatf("v%0d.note", k), {28'd0, note}, t.n);
    chk($sformatf("v%0d.fullnote", k), {25'd0, fullnote}, t.o * 12 + t.n);
    chk($sformatf("v%0d.note_strobes", k), ns_cnt - ns0, t.ns);
    chk($sformatf("v%0d.err_strobes", k), er_cnt - er0, t.er);
  endtask

  initial begin
    rst = 1'b1;
    audio_in = 1'b0;

    // Phase 1: octave/note decoding, note changes, jitter, range edges, errors.
    vecs.push_back(mk(A_EDGE,    50, 0, 0, 0,  0, 0, 0));  // 0 first edge, not captured
    vecs.push_back(mk(A_EDGE,  4096, 0, 0, 0,  0, 0, 0));  // 1 A oct5 seen once
    vecs.push_back(mk(A_EDGE,  4096, 0, 1, 5,  0, 1, 0));  // 2 A oct5 reported
    vecs.push_back(mk(A_EDGE, 10944, 0, 1, 5,  0, 0, 0));  // 3 E oct3 seen once
    vecs.push_back(mk(A_EDGE, 10944, 0, 1, 3,  7, 1, 0));  // 4 E oct3 reported
    vecs.push_back(mk(A_EDGE,  4096, 0, 1, 3,  7, 0, 0));  // 5
    vecs.push_back(mk(A_EDGE,  4096, 0, 1, 5,  0, 1, 0));  // 6 back to A oct5
    vecs.push_back(mk(A_EDGE,  1368, 0, 1, 5,  0, 0, 0));  // 7 E oct6, m=342
    vecs.push_back(mk(A_EDGE,  1366, 0, 1, 6,  7, 1, 0));  // 8 m=341
    vecs.push_back(mk(A_EDGE,  1370, 0, 1, 6,  7, 0, 0));  // 9 jitter, no strobe
    vecs.push_back(mk(A_EDGE,  1367, 0, 1, 6,  7, 0, 0));  // 10
    vecs.push_back(mk(A_EDGE,  1369, 0, 1, 6,  7, 0, 0));  // 11
    vecs.push_back(mk(A_EDGE,  2108, 0, 1, 6,  7, 0, 0));  // 12 m=527 at oct6
    vecs.push_back(mk(A_EDGE,  2111, 0, 1, 6,  0, 1, 0));  // 13 m=527 -> A oct6
    vecs.push_back(mk(A_EDGE,  2112, 0, 1, 6,  0, 0, 0));  // 14 m=528 -> oct5 m=264
    vecs.push_back(mk(A_EDGE,  2112, 0, 1, 5, 11, 1, 0));  // 15 G# oct5
    vecs.push_back(mk(A_EDGE,   100, 0, 1, 5, 11, 0, 1));  // 16 too short
    vecs.push_back(mk(A_EDGE,   100, 0, 1, 5, 11, 0, 1));  // 17
    vecs.push_back(mk(A_EDGE,   100, 0, 1, 5, 11, 0, 1));  // 18
    vecs.push_back(mk(A_EDGE,  2112, 0, 1, 5, 11, 0, 0));  // 19 outputs held
    vecs.push_back(mk(A_EDGE,  2112, 0, 1, 5, 11, 0, 0));  // 20
    // Phase 2: reset while decoding, then a note and a silence timeout.
    vecs.push_back(mk(A_RESET, 2112, 1, 0, 0,  0, 0, 0));  // 21
    vecs.push_back(mk(A_EDGE,    50, 0, 0, 0,  0, 0, 0));  // 22 first post-reset edge
    vecs.push_back(mk(A_EDGE,  1000, 0, 0, 0,  0, 0, 0));  // 23 A oct7 seen once
    vecs.push_back(mk(A_EDGE,  1000, 0, 1, 7,  0, 1, 0));  // 24 A oct7 reported
    vecs.push_back(mk(A_SILENCE,  0, 1, 0, 7,  0, 0, 0));  // 25
    // Phase 3: after silence, alternating notes never become valid.
    vecs.push_back(mk(A_EDGE,    50, 0, 0, 7,  0, 0, 0));  // 26 not captured
    vecs.push_back(mk(A_EDGE,  2000, 0, 0, 7,  0, 0, 0));  // 27 A oct6
    vecs.push_back(mk(A_EDGE,  1000, 0, 0, 7,  0, 0, 0));  // 28 A oct7
    vecs.push_back(mk(A_EDGE,  2000, 0, 0, 7,  0, 0, 0));  // 29
    vecs.push_back(mk(A_EDGE,  1000, 0, 0, 7,  0, 0, 0));  // 30
    vecs.push_back(mk(A_EDGE,   100, 0, 0, 7,  0, 0, 1));  // 31 error while invalid

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.silent", {31'd0, silent}, 1);
    chk("reset.valid", {31'd0, note_valid}, 0);
    chk("reset.fullnote", {25'd0, fullnote}, 0);
    chk("reset.strobes", {30'd0, note_strobe, err_strobe}, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      case (vecs[k].act)
        A_EDGE: begin
          toggle_after(vecs[k].half);
          repeat (CHK) @(posedge clk);
          @(negedge clk);
          check_vec(k, vecs[k]);
        end
        A_RESET: begin
          // Reset lands while the FSM is normalising the captured period.
          toggle_after(vecs[k].half);
          repeat (4) @(posedge clk);
          #1 rst = 1'b1;
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          chk($sformatf("v%0d.silent", k), {31'd0, silent}, vecs[k].s);
          chk($sformatf("v%0d.valid", k), {31'd0, note_valid}, vecs[k].v);
          chk($sformatf("v%0d.octave", k), {29'd0, octave}, vecs[k].o);
          chk($sformatf("v%0d.note", k), {28'd0, note}, vecs[k].n);
          chk($sformatf("v%0d.fullnote", k), {25'd0, fullnote}, 0);
          chk($sformatf("v%0d.strobes", k), {30'd0, note_strobe, err_strobe}, 0);
        end
        A_SILENCE: begin
          // Pin toggled CHK cycles ago; edge pulse follows 3 cycles after
          // the toggle, silence TIMEOUT cycles after that pulse.
          repeat (TO + 3 - CHK) @(posedge clk);
          @(negedge clk);
          chk($sformatf("v%0d.silent_early", k), {31'd0, silent}, 0);
          chk($sformatf("v%0d.valid_early", k), {31'd0, note_valid}, 1);
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("v%0d.silent", k), {31'd0, silent}, vecs[k].s);
          chk($sformatf("v%0d.valid", k), {31'd0, note_valid}, vecs[k].v);
          chk($sformatf("v%0d.octave_held", k), {29'd0, octave}, vecs[k].o);
          chk($sformatf("v%0d.note_held", k), {28'd0, note}, vecs[k].n);
        end
        default: begin
          errors++;
          $display("FAIL v%0d.action: unknown action", k);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
